// File: rtl/timer_ctrl_pkg.sv
// Purpose: shared constants, state encodings and event-code helpers for the timer IRQ controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package timer_ctrl_pkg;

   localparam int N_TIMER = 3;
   localparam int N_PEND  = 2 * N_TIMER;

   // CTRL register bit positions
   localparam int CTRL_EN       = 0;
   localparam int CTRL_ONE_SHOT = 1;
   localparam int CTRL_CMP_IE   = 2;
   localparam int CTRL_OVF_IE   = 3;
   localparam int CTRL_START    = 4;

   // cfg_addr codes
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_COMP   = 2'd1;
   localparam logic [1:0] ADDR_OFFSET = 2'd2;
   localparam logic [1:0] ADDR_STEP   = 2'd3;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_LOAD = 2'd1,
      CH_RUN  = 2'd2,
      CH_HALT = 2'd3
   } chan_state_t;

   typedef enum logic {
      A_IDLE    = 1'b0,
      A_PRESENT = 1'b1
   } arb_state_t;

   // Stored part of CTRL; start is a strobe and is never held.
   typedef struct packed {
      logic ovf_ie;
      logic cmp_ie;
      logic one_shot;
      logic enable;
   } ctrl_t;

   localparam logic [7:0] CODE_CMP0 = 8'h01;
   localparam logic [7:0] CODE_OVF0 = 8'h02;
   localparam logic [7:0] CODE_CMP1 = 8'h03;
   localparam logic [7:0] CODE_OVF1 = 8'h04;
   localparam logic [7:0] CODE_CMP2 = 8'h05;
   localparam logic [7:0] CODE_OVF2 = 8'h06;

   // Lowest channel first; within a channel the overflow bit (odd) beats compare (even).
   function automatic logic [2:0] pick_pending(input logic [N_PEND-1:0] p);
      logic [2:0] idx;
      idx = 3'd0;
      if      (p[1]) idx = 3'd1;
      else if (p[0]) idx = 3'd0;
      else if (p[3]) idx = 3'd3;
      else if (p[2]) idx = 3'd2;
      else if (p[5]) idx = 3'd5;
      else if (p[4]) idx = 3'd4;
      return idx;
   endfunction

   function automatic logic [7:0] pend_code(input logic [2:0] idx);
      logic [7:0] code;
      case (idx)
         3'd0:    code = CODE_CMP0;
         3'd1:    code = CODE_OVF0;
         3'd2:    code = CODE_CMP1;
         3'd3:    code = CODE_OVF1;
         3'd4:    code = CODE_CMP2;
         3'd5:    code = CODE_OVF2;
         default: code = 8'h00;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/timer_chan_fsm.sv
// Purpose: one timer channel - config registers plus IDLE/LOAD/RUN/HALT sequencing of the counter.
// Latency: config writes visible the cycle after the write edge; start gives a 1-cycle clear then enable.
// Backpressure: none; every write and event is absorbed in the cycle it arrives.
// Ports: wr_en/addr/wdata = channel-local config write; evt_cmp = compare pulse (one-shot halt);
//        en/clear/comp/offset/step = counter controls; cmp_ie/ovf_ie = interrupt enables for the top.
module timer_chan_fsm
   import timer_ctrl_pkg::*;
#(
   parameter int WORD     = 8,
   parameter int STEP_CNT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [1:0]          addr,
   input  logic [WORD-1:0]     wdata,
   input  logic                evt_cmp,
   output logic                en,
   output logic                clear,
   output logic [WORD-1:0]     comp,
   output logic [WORD-1:0]     offset,
   output logic [STEP_CNT-1:0] step,
   output logic                cmp_ie,
   output logic                ovf_ie
);

   ctrl_t       ctrl_q;
   chan_state_t state_q;
   chan_state_t state_d;
   logic        ctrl_wr;

   assign ctrl_wr = wr_en && (addr == ADDR_CTRL);
   assign cmp_ie  = ctrl_q.cmp_ie;
   assign ovf_ie  = ctrl_q.ovf_ie;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q <= '0;
         comp   <= '0;
         offset <= '0;
         step   <= '0;
      end else if (wr_en) begin
         case (addr)
            ADDR_CTRL:   ctrl_q <= ctrl_t'(wdata[3:0]);
            ADDR_COMP:   comp   <= wdata;
            ADDR_OFFSET: offset <= wdata;
            default:     step   <= wdata[STEP_CNT-1:0];
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= CH_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      en      = 1'b0;
      clear   = 1'b0;
      case (state_q)
         CH_LOAD: begin
            clear   = 1'b1;
            state_d = CH_RUN;
         end
         CH_RUN: begin
            en = 1'b1;
            if (evt_cmp && ctrl_q.one_shot) state_d = CH_HALT;
         end
         default: ;
      endcase
      // A CTRL write overrides normal sequencing: disable wins over start,
      // and start (with enable) restarts from any state.
      if (ctrl_wr) begin
         if (!wdata[CTRL_EN])        state_d = CH_IDLE;
         else if (wdata[CTRL_START]) state_d = CH_LOAD;
      end
   end

endmodule

// File: rtl/timer_irq_controller.sv
// Purpose: three timer channels, masked pending flags and a one-at-a-time IRQ presenter to the core.
// Latency: event pulse -> pending next cycle -> irq_valid the cycle after; ack -> next valid 2 cycles later.
// Backpressure: irq_instr held until irq_ack; further events coalesce in pending meanwhile.
// Ports: cfg_* = config write bus; evt_cmp/evt_ovf = counter event pulses; tmr_* = counter controls;
//        irq_valid/irq_instr/irq_ack = event handshake to the core; pending = latched status.
module timer_irq_controller
   import timer_ctrl_pkg::*;
#(
   parameter int WORD     = 8,
   parameter int DWORD    = 16,
   parameter int STEP_CNT = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cfg_we,
   input  logic [1:0]                  cfg_sel,
   input  logic [1:0]                  cfg_addr,
   input  logic [WORD-1:0]             cfg_wdata,
   input  logic [N_TIMER-1:0]          evt_cmp,
   input  logic [N_TIMER-1:0]          evt_ovf,
   output logic [N_TIMER-1:0]          tmr_en,
   output logic [N_TIMER-1:0]          tmr_clear,
   output logic [N_TIMER*WORD-1:0]     tmr_comp,
   output logic [N_TIMER*WORD-1:0]     tmr_offset,
   output logic [N_TIMER*STEP_CNT-1:0] tmr_step,
   output logic                        irq_valid,
   output logic [DWORD-1:0]            irq_instr,
   input  logic                        irq_ack,
   output logic [2*N_TIMER-1:0]        pending
);

   logic [N_TIMER-1:0] cmp_ie;
   logic [N_TIMER-1:0] ovf_ie;
   logic [N_PEND-1:0]  pend_q;
   logic [N_PEND-1:0]  pend_set;
   logic [N_PEND-1:0]  pend_clr;
   logic [2:0]         sel_q;
   logic               arb_load;
   arb_state_t         arb_q;
   arb_state_t         arb_d;

   for (genvar i = 0; i < N_TIMER; i++) begin : g_chan
      localparam logic [1:0] SEL = 2'(i);

      timer_chan_fsm #(
         .WORD     (WORD),
         .STEP_CNT (STEP_CNT)
      ) u_chan (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (cfg_we && (cfg_sel == SEL)),
         .addr    (cfg_addr),
         .wdata   (cfg_wdata),
         .evt_cmp (evt_cmp[i]),
         .en      (tmr_en[i]),
         .clear   (tmr_clear[i]),
         .comp    (tmr_comp[i*WORD +: WORD]),
         .offset  (tmr_offset[i*WORD +: WORD]),
         .step    (tmr_step[i*STEP_CNT +: STEP_CNT]),
         .cmp_ie  (cmp_ie[i]),
         .ovf_ie  (ovf_ie[i])
      );

      assign pend_set[2*i]   = evt_cmp[i] && cmp_ie[i];
      assign pend_set[2*i+1] = evt_ovf[i] && ovf_ie[i];
   end

   assign pending   = pend_q;
   assign irq_valid = (arb_q == A_PRESENT);

   always_comb begin
      arb_d    = arb_q;
      arb_load = 1'b0;
      pend_clr = '0;
      case (arb_q)
         A_IDLE: begin
            if (|pend_q) begin
               arb_load = 1'b1;
               arb_d    = A_PRESENT;
            end
         end
         A_PRESENT: begin
            if (irq_ack) begin
               pend_clr[sel_q] = 1'b1;
               arb_d           = A_IDLE;
            end
         end
         default: arb_d = A_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arb_q     <= A_IDLE;
         sel_q     <= '0;
         irq_instr <= '0;
         pend_q    <= '0;
      end else begin
         arb_q  <= arb_d;
         // set is ORed after the clear so a fresh event on the acked bit survives
         pend_q <= (pend_q & ~pend_clr) | pend_set;
         if (arb_load) begin
            sel_q     <= pick_pending(pend_q);
            irq_instr <= DWORD'(pend_code(pick_pending(pend_q)));
         end else if (arb_q == A_PRESENT && irq_ack) begin
            irq_instr <= '0;
         end
      end
   end

endmodule
